mpu_bus_bridge: RTL and testbench
=================================

Name: mpu_bus_bridge

Overview:
- Downstream neighbour of the MC6502 MPU top.
- Consumes ABL/ABH/R_W/DB_OUT from the MPU and produces its DB_IN and RDY.
- Converts each MPU bus cycle into a req/ack transaction on a 16-bit-address, 8-bit-data memory port.
- Stalls the MPU through RDY until the memory acknowledges or a timeout aborts the access.

Parameters:
- TIMEOUT, 16: REQ cycles allowed without MEM_ACK before the access aborts; 0 disables the timeout.
- ERR_DATA, 8'hFF: read data returned to the MPU on an aborted read.

Ports:
- CLK  input  1  system clock, rising edge
- RES_N  input  1  asynchronous active-low reset
- ABL  input  8  MPU address low
- ABH  input  8  MPU address high
- R_W  input  1  MPU direction, 1=read, 0=write
- DB_OUT  input  8  MPU write data
- RDY  output  1  MPU advance enable; MPU holds its state (all cycle types) while 0
- DB_IN  output  8  read data to MPU
- MEM_REQ  output  1  memory request
- MEM_WE  output  1  1=write transaction
- MEM_ADDR  output  16  {ABH,ABL} as latched
- MEM_WDATA  output  8  latched DB_OUT
- MEM_RDATA  input  8  memory read data, valid in the MEM_ACK cycle
- MEM_ACK  input  1  transaction complete, sampled on the rising edge
- BUS_ERR  output  1  sticky timeout flag
- BUS_ERR_CLR  input  1  synchronous clear of BUS_ERR

Behaviour:
- Reset (async, RES_N=0):
  - State IDLE.
  - RDY, DB_IN, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA and BUS_ERR all reset to 0.
  - Timeout counter resets to 0.
  - Reset during REQ drops MEM_REQ immediately; the memory tolerates an abandoned request.
- All outputs are registered; no combinational path from input to output.
- IDLE:
  - RDY=0.
  - At the edge, latch MEM_ADDR={ABH,ABL}, MEM_WE=~R_W, MEM_WDATA=DB_OUT.
  - Set MEM_REQ=1, clear the counter, go to REQ.
- REQ:
  - MEM_REQ=1; address and data are held stable.
  - Edge with MEM_ACK=1: MEM_REQ<=0; if read, DB_IN<=MEM_RDATA; go to DONE.
  - Edge with MEM_ACK=0: counter++.
  - If TIMEOUT!=0, counter==TIMEOUT-1 and no ack: MEM_REQ<=0, BUS_ERR<=1; DB_IN<=ERR_DATA if read; go to DONE.
  - Ack in the same cycle as timeout expiry: ack wins, no error.
- DONE:
  - RDY=1 for exactly one cycle; the MPU advances at this edge.
  - DB_IN is held until the next read completes (writes leave DB_IN unchanged).
  - Next state IDLE.
- Latency: minimum 3 clocks per MPU cycle (IDLE, REQ with ack in the first cycle, DONE); each additional wait cycle adds 1.
- Counter width is clog2(TIMEOUT+1); no wrap, since the abort occurs before overflow.
- BUS_ERR: set by a timeout, cleared by BUS_ERR_CLR. If set and clear occur in the same cycle, set wins.
- MEM_ACK outside REQ is ignored.

Optional Feature:
- Macro: MPU_BUS_WPOST_EN.
- Enabled (single-entry posted write buffer):
  - An IDLE write latches MEM_ADDR/MEM_WDATA/MEM_WE=1, asserts MEM_REQ and goes directly to DONE, giving a 2-clock write.
  - The buffer drains in the background under the same ack/timeout rules.
  - An IDLE access arriving while the buffer is still pending stays in IDLE with RDY=0 until the drain completes, then proceeds normally.
  - A posted-write timeout sets BUS_ERR only.
- Disabled: writes follow the same IDLE/REQ/DONE path as reads.

Decomposition:
- Shared package (mpu_bus_pkg): state encoding constants (IDLE, REQ, DONE), default ERR_DATA, default TIMEOUT.
- One sub-module, bus_timeout:
  - Inputs: clear, count-enable.
  - Parameter: TIMEOUT.
  - Output: expire pulse when count==TIMEOUT-1 with enable high.
  - TIMEOUT=0 forces expire=0.

Test Plan:
- Read, ack in the first REQ cycle, addr 16'h1234, MEM_RDATA=8'hA5 -> MEM_ADDR=1234, MEM_WE=0, RDY=1 on the third clock, DB_IN=A5, BUS_ERR=0.
- Write of 8'h3C to 16'h00FF, ack after 4 wait cycles -> MEM_REQ high for 5 clocks, MEM_WDATA=3C, MEM_WE=1, RDY pulse on clock 7, DB_IN unchanged.
- Read with no ack, TIMEOUT=16 -> MEM_REQ drops after 16 REQ cycles, DB_IN=FF, BUS_ERR=1; BUS_ERR_CLR pulse -> BUS_ERR=0.
- Ack arriving exactly in the 16th REQ cycle with MEM_RDATA=8'h77 -> DB_IN=77, BUS_ERR stays 0.
- RES_N pulled low in the second REQ cycle -> MEM_REQ=0 and RDY=0 immediately; after release, the bridge is in IDLE and the next access completes normally.
- MPU_BUS_WPOST_EN defined: write followed immediately by a read, write ack delayed 3 cycles -> write RDY pulse on clock 2; the read waits in IDLE until the drain, then returns the correct data.

Source files
------------

// File: rtl/mpu_bus_pkg.sv
// Shared definitions for the MPU bus bridge.
//   bridge_state_e   : bridge FSM state encoding (IDLE, REQ, DONE)
//   DefaultTimeout   : default REQ-cycle budget before an access aborts
//   DefaultErrData   : default read data returned on an aborted read
//   cnt_width()      : timeout counter width for a given budget
package mpu_bus_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } bridge_state_e;

    localparam int unsigned DefaultTimeout = 16;
    localparam logic [7:0]  DefaultErrData = 8'hFF;

    // clog2(timeout+1); a disabled timeout still needs a 1-bit counter to elaborate.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mpu_bus_bridge_if.sv
// Bus bundle between the MPU, the bridge and the memory port.
//   MPU side    : ABL, ABH, R_W, DB_OUT (to bridge); RDY, DB_IN (from bridge)
//   Memory side : MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA (from bridge);
//                 MEM_RDATA, MEM_ACK (to bridge)
//   Status      : BUS_ERR (from bridge), BUS_ERR_CLR (to bridge)
// Modport master is the bridge itself; modport slave is its environment.
interface mpu_bus_bridge_if;

    logic [7:0]  ABL;
    logic [7:0]  ABH;
    logic        R_W;
    logic [7:0]  DB_OUT;
    logic        RDY;
    logic [7:0]  DB_IN;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [15:0] MEM_ADDR;
    logic [7:0]  MEM_WDATA;
    logic [7:0]  MEM_RDATA;
    logic        MEM_ACK;
    logic        BUS_ERR;
    logic        BUS_ERR_CLR;

    modport master (
        input  ABL, ABH, R_W, DB_OUT, MEM_RDATA, MEM_ACK, BUS_ERR_CLR,
        output RDY, DB_IN, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, BUS_ERR
    );

    modport slave (
        output ABL, ABH, R_W, DB_OUT, MEM_RDATA, MEM_ACK, BUS_ERR_CLR,
        input  RDY, DB_IN, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, BUS_ERR
    );

endinterface

// File: rtl/bus_timeout.sv
// Request timeout counter for the MPU bus bridge.
//   CLK, RES_N : clock, asynchronous active-low reset
//   clear      : restart the count at zero
//   count_en   : one REQ cycle elapsed without completion
//   expire     : high when count_en is set on the last allowed cycle (TIMEOUT-1)
// TIMEOUT = 0 disables the timeout (expire stays low).
module bus_timeout
    import mpu_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic CLK,
    input  logic RES_N,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam int unsigned     CntW    = cnt_width(TIMEOUT);
    localparam logic [CntW-1:0] LastCnt = (TIMEOUT == 0) ? '0 : CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q;

    // Saturates at LastCnt: the access aborts there, so the counter never wraps.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (count_en && (cnt_q != LastCnt)) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign expire = (TIMEOUT != 0) && count_en && (cnt_q == LastCnt);

endmodule

// File: rtl/mpu_bus_bridge.sv
// MPU bus bridge: turns each MPU bus cycle into a req/ack transaction on a
// 16-bit-address, 8-bit-data memory port and stalls the MPU through RDY until
// the memory acknowledges or the timeout aborts the access.
//   CLK, RES_N : clock, asynchronous active-low reset
//   bus        : mpu_bus_bridge_if.master (MPU, memory and error-flag signals)
// Parameters:
//   TIMEOUT    : REQ cycles allowed without MEM_ACK (0 = no timeout)
//   ERR_DATA   : read data returned on an aborted read
// Build option:
//   MPU_BUS_WPOST_EN : single-entry posted write buffer; writes complete in
//                      2 clocks and drain in the background.
// All outputs are registered.
module mpu_bus_bridge
    import mpu_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT  = DefaultTimeout,
    parameter logic [7:0]  ERR_DATA = DefaultErrData
) (
    input logic              CLK,
    input logic              RES_N,
    mpu_bus_bridge_if.master bus
);

    bridge_state_e state_q;
    logic          rdy_q;
    logic          req_q;
    logic          we_q;
    logic          err_q;
    logic [7:0]    db_in_q;
    logic [7:0]    wdata_q;
    logic [15:0]   addr_q;

    logic tmo_clear;
    logic tmo_count;
    logic tmo_expire;

`ifdef MPU_BUS_WPOST_EN
    // A posted write is still in flight on the memory port.
    logic wp_pend_q;

    assign tmo_clear = (state_q == StIdle) && !wp_pend_q;
    assign tmo_count = (state_q == StReq) || wp_pend_q;
`else
    assign tmo_clear = (state_q == StIdle);
    assign tmo_count = (state_q == StReq);
`endif

    bus_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .CLK     (CLK),
        .RES_N   (RES_N),
        .clear   (tmo_clear),
        .count_en(tmo_count),
        .expire  (tmo_expire)
    );

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state_q   <= StIdle;
            rdy_q     <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            db_in_q   <= 8'h00;
            wdata_q   <= 8'h00;
            addr_q    <= 16'h0000;
`ifdef MPU_BUS_WPOST_EN
            wp_pend_q <= 1'b0;
`endif
        end else begin
            // Clear first so that a timeout in the same cycle overrides it.
            if (bus.BUS_ERR_CLR) begin
                err_q <= 1'b0;
            end

`ifdef MPU_BUS_WPOST_EN
            // Background drain; a posted write never touches DB_IN.
            if (wp_pend_q) begin
                if (bus.MEM_ACK) begin
                    req_q     <= 1'b0;
                    wp_pend_q <= 1'b0;
                end else if (tmo_expire) begin
                    req_q     <= 1'b0;
                    err_q     <= 1'b1;
                    wp_pend_q <= 1'b0;
                end
            end
`endif

            unique case (state_q)
                StIdle: begin
                    rdy_q <= 1'b0;
`ifdef MPU_BUS_WPOST_EN
                    // Hold the MPU here until the buffered write has drained.
                    if (!wp_pend_q) begin
                        addr_q  <= {bus.ABH, bus.ABL};
                        we_q    <= ~bus.R_W;
                        wdata_q <= bus.DB_OUT;
                        req_q   <= 1'b1;
                        if (!bus.R_W) begin
                            wp_pend_q <= 1'b1;
                            rdy_q     <= 1'b1;
                            state_q   <= StDone;
                        end else begin
                            state_q <= StReq;
                        end
                    end
`else
                    addr_q  <= {bus.ABH, bus.ABL};
                    we_q    <= ~bus.R_W;
                    wdata_q <= bus.DB_OUT;
                    req_q   <= 1'b1;
                    state_q <= StReq;
`endif
                end

                StReq: begin
                    // Ack takes priority over a timeout expiring in the same cycle.
                    if (bus.MEM_ACK) begin
                        req_q   <= 1'b0;
                        rdy_q   <= 1'b1;
                        state_q <= StDone;
                        if (!we_q) begin
                            db_in_q <= bus.MEM_RDATA;
                        end
                    end else if (tmo_expire) begin
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        rdy_q   <= 1'b1;
                        state_q <= StDone;
                        if (!we_q) begin
                            db_in_q <= ERR_DATA;
                        end
                    end
                end

                StDone: begin
                    rdy_q   <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    rdy_q   <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.RDY       = rdy_q;
    assign bus.DB_IN     = db_in_q;
    assign bus.MEM_REQ   = req_q;
    assign bus.MEM_WE    = we_q;
    assign bus.MEM_ADDR  = addr_q;
    assign bus.MEM_WDATA = wdata_q;
    assign bus.BUS_ERR   = err_q;

endmodule

// File: tb/tb_mpu_bus_bridge.sv
// Self-checking bench for mpu_bus_bridge (TIMEOUT=16, ERR_DATA=8'hFF).
// The bench plays both the MPU and the memory; expected DB_IN values go into
// a scoreboard queue when an access is issued and are popped when RDY rises.
module tb_mpu_bus_bridge;

    logic CLK = 1'b0;
    logic RES_N;

    mpu_bus_bridge_if bus ();

    mpu_bus_bridge #(
        .TIMEOUT (16),
        .ERR_DATA(8'hFF)
    ) dut (
        .CLK  (CLK),
        .RES_N(RES_N),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_db;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Runs one MPU cycle from IDLE. ack_after = REQ cycles without ack before
    // the ack cycle (-1: never ack). clr_mode: 0 none, 1 pulse BUS_ERR_CLR on
    // the first edge, 2 hold it until RDY. Clocks are numbered from 1 (IDLE).
    task automatic run_access(input logic rw, input logic [15:0] addr,
                              input logic [7:0] wdata, input int ack_after,
                              input logic [7:0] rdata, input int clr_mode,
                              output int rdy_clk, output int req_cycles,
                              output logic [15:0] seen_addr, output logic seen_we,
                              output logic [7:0] seen_wdata, output logic [7:0] seen_db);
        int edges = 0;
        rdy_clk    = -1;
        req_cycles = 0;
        seen_addr  = 16'h0;
        seen_we    = 1'b0;
        seen_wdata = 8'h0;
        seen_db    = 8'h0;
        bus.ABL         = addr[7:0];
        bus.ABH         = addr[15:8];
        bus.R_W         = rw;
        bus.DB_OUT      = wdata;
        bus.MEM_ACK     = 1'b0;
        bus.MEM_RDATA   = ~rdata;
        bus.BUS_ERR_CLR = (clr_mode != 0);
        while (rdy_clk < 0 && edges < 200) begin
            tick();
            edges++;
            if (clr_mode == 1) bus.BUS_ERR_CLR = 1'b0;
            if (bus.MEM_REQ) begin
                req_cycles++;
                if (req_cycles == 1) begin
                    seen_addr  = bus.MEM_ADDR;
                    seen_we    = bus.MEM_WE;
                    seen_wdata = bus.MEM_WDATA;
                end
                bus.MEM_ACK   = (req_cycles == ack_after + 1);
                bus.MEM_RDATA = bus.MEM_ACK ? rdata : ~rdata;
            end else begin
                bus.MEM_ACK = 1'b0;
            end
            if (bus.RDY) begin
                rdy_clk = edges + 1;
                seen_db = bus.DB_IN;
            end
        end
        bus.MEM_ACK     = 1'b0;
        bus.BUS_ERR_CLR = 1'b0;
        if (rdy_clk >= 0) tick();  // MPU advance edge, back to IDLE
    endtask

    task automatic test_reset();
        RES_N           = 1'b0;
        bus.ABL         = 8'h0;
        bus.ABH         = 8'h0;
        bus.R_W         = 1'b1;
        bus.DB_OUT      = 8'h0;
        bus.MEM_RDATA   = 8'h0;
        bus.MEM_ACK     = 1'b0;
        bus.BUS_ERR_CLR = 1'b0;
        #3;
        n_checks++;
        if ({bus.RDY, bus.MEM_REQ, bus.MEM_WE, bus.BUS_ERR} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000",
                     {bus.RDY, bus.MEM_REQ, bus.MEM_WE, bus.BUS_ERR});
        else n_pass++;
        n_checks++;
        if (bus.DB_IN !== 8'h00) $display("FAIL reset_db_in: got %h want 00", bus.DB_IN);
        else n_pass++;
        n_checks++;
        if (bus.MEM_ADDR !== 16'h0000)
            $display("FAIL reset_mem_addr: got %h want 0000", bus.MEM_ADDR);
        else n_pass++;
        n_checks++;
        if (bus.MEM_WDATA !== 8'h00)
            $display("FAIL reset_mem_wdata: got %h want 00", bus.MEM_WDATA);
        else n_pass++;
        model_db = 8'h00;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RES_N = 1'b1;
    endtask

    task automatic test_read();
        int rc, rq; logic [15:0] a; logic we; logic [7:0] wd, db, e;
        exp_q.push_back(8'hA5);
        model_db = 8'hA5;
        run_access(1'b1, 16'h1234, 8'h00, 0, 8'hA5, 0, rc, rq, a, we, wd, db);
        e = exp_q.pop_front();
        n_checks++;
        if (rc !== 3) $display("FAIL read_rdy_clock: got %0d want 3", rc); else n_pass++;
        n_checks++;
        if (a !== 16'h1234) $display("FAIL read_addr: got %h want 1234", a); else n_pass++;
        n_checks++;
        if (we !== 1'b0) $display("FAIL read_we: got %b want 0", we); else n_pass++;
        n_checks++;
        if (db !== e) $display("FAIL read_db_in: got %h want %h", db, e); else n_pass++;
        n_checks++;
        if (bus.BUS_ERR !== 1'b0) $display("FAIL read_bus_err: got %b want 0", bus.BUS_ERR);
        else n_pass++;
        n_checks++;
        if (bus.RDY !== 1'b0) $display("FAIL read_rdy_one_cycle: got %b want 0", bus.RDY);
        else n_pass++;
    endtask

    task automatic test_write();
        int rc, rq; logic [15:0] a; logic we; logic [7:0] wd, db, e;
        exp_q.push_back(model_db);
        run_access(1'b0, 16'h00FF, 8'h3C, 4, 8'h11, 0, rc, rq, a, we, wd, db);
        e = exp_q.pop_front();
        n_checks++;
        if (rq !== 5) $display("FAIL write_req_cycles: got %0d want 5", rq); else n_pass++;
        n_checks++;
        if (wd !== 8'h3C) $display("FAIL write_wdata: got %h want 3c", wd); else n_pass++;
        n_checks++;
        if (we !== 1'b1) $display("FAIL write_we: got %b want 1", we); else n_pass++;
        n_checks++;
        if (a !== 16'h00FF) $display("FAIL write_addr: got %h want 00ff", a); else n_pass++;
        n_checks++;
        if (rc !== 7) $display("FAIL write_rdy_clock: got %0d want 7", rc); else n_pass++;
        n_checks++;
        if (db !== e) $display("FAIL write_db_in_kept: got %h want %h", db, e); else n_pass++;
    endtask

    task automatic test_timeout();
        int rc, rq; logic [15:0] a; logic we; logic [7:0] wd, db, e;
        exp_q.push_back(8'hFF);
        model_db = 8'hFF;
        run_access(1'b1, 16'hBEEF, 8'h00, -1, 8'h00, 0, rc, rq, a, we, wd, db);
        e = exp_q.pop_front();
        n_checks++;
        if (rq !== 16) $display("FAIL timeout_req_cycles: got %0d want 16", rq); else n_pass++;
        n_checks++;
        if (rc !== 18) $display("FAIL timeout_rdy_clock: got %0d want 18", rc); else n_pass++;
        n_checks++;
        if (db !== e) $display("FAIL timeout_db_in: got %h want %h", db, e); else n_pass++;
        n_checks++;
        if (bus.BUS_ERR !== 1'b1) $display("FAIL timeout_bus_err: got %b want 1", bus.BUS_ERR);
        else n_pass++;
        // Clear pulse during the next (good) access.
        exp_q.push_back(8'h5A);
        model_db = 8'h5A;
        run_access(1'b1, 16'h0102, 8'h00, 0, 8'h5A, 1, rc, rq, a, we, wd, db);
        e = exp_q.pop_front();
        n_checks++;
        if (bus.BUS_ERR !== 1'b0) $display("FAIL bus_err_clear: got %b want 0", bus.BUS_ERR);
        else n_pass++;
        n_checks++;
        if (db !== e) $display("FAIL after_clear_db_in: got %h want %h", db, e); else n_pass++;
        // Clear held through a timeout: the set wins.
        exp_q.push_back(8'hFF);
        model_db = 8'hFF;
        run_access(1'b1, 16'h0203, 8'h00, -1, 8'h00, 2, rc, rq, a, we, wd, db);
        e = exp_q.pop_front();
        n_checks++;
        if (bus.BUS_ERR !== 1'b1) $display("FAIL set_beats_clear: got %b want 1", bus.BUS_ERR);
        else n_pass++;
        n_checks++;
        if (db !== e) $display("FAIL set_beats_clear_db: got %h want %h", db, e); else n_pass++;
        exp_q.push_back(8'h00);
        model_db = 8'h00;
        run_access(1'b1, 16'h0304, 8'h00, 1, 8'h00, 1, rc, rq, a, we, wd, db);
        e = exp_q.pop_front();
        n_checks++;
        if (bus.BUS_ERR !== 1'b0) $display("FAIL bus_err_clear2: got %b want 0", bus.BUS_ERR);
        else n_pass++;
    endtask

    task automatic test_ack_at_expiry();
        int rc, rq; logic [15:0] a; logic we; logic [7:0] wd, db, e;
        exp_q.push_back(8'h77);
        model_db = 8'h77;
        run_access(1'b1, 16'h4455, 8'h00, 15, 8'h77, 0, rc, rq, a, we, wd, db);
        e = exp_q.pop_front();
        n_checks++;
        if (db !== e) $display("FAIL expiry_ack_db_in: got %h want %h", db, e); else n_pass++;
        n_checks++;
        if (bus.BUS_ERR !== 1'b0) $display("FAIL expiry_ack_bus_err: got %b want 0", bus.BUS_ERR);
        else n_pass++;
        n_checks++;
        if (rc !== 18) $display("FAIL expiry_ack_rdy_clock: got %0d want 18", rc); else n_pass++;
    endtask

    task automatic test_reset_mid_req();
        int rc, rq; logic [15:0] a; logic we; logic [7:0] wd, db, e;
        bus.ABL     = 8'h21;
        bus.ABH     = 8'h43;
        bus.R_W     = 1'b1;
        bus.MEM_ACK = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.MEM_REQ !== 1'b1) $display("FAIL mid_req_active: got %b want 1", bus.MEM_REQ);
        else n_pass++;
        #2;
        RES_N = 1'b0;
        #1;
        n_checks++;
        if ({bus.MEM_REQ, bus.RDY} !== 2'b00)
            $display("FAIL mid_req_reset_drop: got %b want 00", {bus.MEM_REQ, bus.RDY});
        else n_pass++;
        model_db = 8'h00;
        @(negedge CLK);
        RES_N = 1'b1;
        exp_q.push_back(8'hC3);
        model_db = 8'hC3;
        run_access(1'b1, 16'h9876, 8'h00, 0, 8'hC3, 0, rc, rq, a, we, wd, db);
        e = exp_q.pop_front();
        n_checks++;
        if (rc !== 3) $display("FAIL post_reset_rdy_clock: got %0d want 3", rc); else n_pass++;
        n_checks++;
        if (db !== e) $display("FAIL post_reset_db_in: got %h want %h", db, e); else n_pass++;
        n_checks++;
        if (a !== 16'h9876) $display("FAIL post_reset_addr: got %h want 9876", a); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int rc, rq, wait_n; logic [15:0] a, addr; logic we, rw; logic [7:0] wd, db, e, wdata, rdata;
        for (int i = 0; i < 8; i++) begin
            rw     = 1'($urandom_range(0, 1));
            addr   = 16'($urandom);
            wdata  = 8'($urandom);
            rdata  = 8'($urandom);
            wait_n = int'($urandom_range(0, 3));
            if (rw) model_db = rdata;
            exp_q.push_back(model_db);
            run_access(rw, addr, wdata, wait_n, rdata, 0, rc, rq, a, we, wd, db);
            e = exp_q.pop_front();
            n_checks++;
            if (rc !== 3 + wait_n)
                $display("FAIL b2b_rdy_clock[%0d]: got %0d want %0d", i, rc, 3 + wait_n);
            else n_pass++;
            n_checks++;
            if ({a, we} !== {addr, ~rw})
                $display("FAIL b2b_addr_we[%0d]: got %h/%b want %h/%b", i, a, we, addr, ~rw);
            else n_pass++;
            n_checks++;
            if (db !== e) $display("FAIL b2b_db_in[%0d]: got %h want %h", i, db, e); else n_pass++;
            if (!rw) begin
                n_checks++;
                if (wd !== wdata) $display("FAIL b2b_wdata[%0d]: got %h want %h", i, wd, wdata);
                else n_pass++;
            end
        end
    endtask

    // Write with a 3-wait drain, immediately followed by a read.
    task automatic test_posted_write();
        int edges = 0, req_run = 0, wr_rdy = -1, rd_rdy = -1;
        logic [7:0] db = 8'h00;
        logic [15:0] rd_addr = 16'h0000;
        bit rd_phase = 1'b0;
        bus.ABL     = 8'h00;
        bus.ABH     = 8'h20;
        bus.R_W     = 1'b0;
        bus.DB_OUT  = 8'h5E;
        bus.MEM_ACK = 1'b0;
        while (rd_rdy < 0 && edges < 100) begin
            tick();
            edges++;
            if (bus.MEM_REQ) begin
                req_run++;
                if (!bus.MEM_WE) rd_addr = bus.MEM_ADDR;
            end else begin
                req_run = 0;
            end
            bus.MEM_ACK   = bus.MEM_REQ && (req_run == (bus.MEM_WE ? 4 : 1));
            bus.MEM_RDATA = 8'h6D;
            if (bus.RDY) begin
                if (!rd_phase) begin
                    wr_rdy   = edges + 1;
                    rd_phase = 1'b1;
                    bus.ABL  = 8'h40;
                    bus.ABH  = 8'h30;
                    bus.R_W  = 1'b1;
                end else begin
                    rd_rdy = edges + 1;
                    db     = bus.DB_IN;
                end
            end
        end
        bus.MEM_ACK = 1'b0;
        if (rd_rdy >= 0) tick();
        n_checks++;
        if (wr_rdy !== 2) $display("FAIL posted_wr_rdy_clock: got %0d want 2", wr_rdy);
        else n_pass++;
        n_checks++;
        if (rd_rdy !== 8) $display("FAIL posted_rd_rdy_clock: got %0d want 8", rd_rdy);
        else n_pass++;
        n_checks++;
        if (db !== 8'h6D) $display("FAIL posted_rd_db_in: got %h want 6d", db); else n_pass++;
        n_checks++;
        if (rd_addr !== 16'h3040) $display("FAIL posted_rd_addr: got %h want 3040", rd_addr);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_read();
`ifdef MPU_BUS_WPOST_EN
        test_posted_write();
`else
        test_write();
`endif
        test_timeout();
        test_ack_at_expiry();
        test_reset_mid_req();
`ifndef MPU_BUS_WPOST_EN
        test_back_to_back();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
